mmu_sequencer: RTL and testbench

MMU_SEQUENCER -- requirements
Module: mmu_sequencer

---
 rtl/mmu_sequencer_if.sv | 29 ++
 rtl/mmu_sequencer.sv | 97 +++++++++
 tb/tb_mmu_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_sequencer_if.sv
// rtl/mmu_sequencer_if.sv - host, memory and feeder signal bundle for mmu_sequencer
interface mmu_sequencer_if;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mmu_en;
    logic [2:0] mmu_cycle;
    logic       feeder_done;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       busy;
    logic       err;

    modport master (
        input  start, in_valid, in_data, feeder_done,
        output in_ready, mem_we, mem_addr, mem_wdata, mmu_en, mmu_cycle,
               out_valid, out_idx, busy, err
    );

    modport slave (
        output start, in_valid, in_data, feeder_done,
        input  in_ready, mem_we, mem_addr, mem_wdata, mmu_en, mmu_cycle,
               out_valid, out_idx, busy, err
    );
endinterface

// File: rtl/mmu_sequencer.sv
// rtl/mmu_sequencer.sv - load/compute/drain job sequencer for the matrix unit feeder
module mmu_sequencer #(
    parameter int LOAD_BYTES  = 8,
    parameter int DRAIN_BYTES = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic          clk,
    input  logic          rst,
    mmu_sequencer_if.master bus
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t        state, state_nx;
    logic [2:0]    byte_cnt;
    logic [WW-1:0] watchdog;
    logic          accept, last_byte, timeout_hit, last_out, active, active_nx;
    logic          mem_we_q, err_q;
    logic [2:0]    mem_addr_q, mmu_cycle_q, out_idx_q;
    logic [7:0]    mem_wdata_q;

    assign accept      = (state == LOAD) && bus.in_valid;
    assign last_byte   = (byte_cnt == 3'(LOAD_BYTES - 1));
    assign timeout_hit = (watchdog == WW'(TIMEOUT - 1));
    assign last_out    = (out_idx_q == 3'(DRAIN_BYTES - 1));
    assign active      = (state == COMPUTE) || (state == DRAIN);
    assign active_nx   = (state_nx == COMPUTE) || (state_nx == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.mmu_en    = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            IDLE:    if (bus.start) state_nx = LOAD;
            LOAD: begin
                bus.in_ready = 1'b1;
                if (accept && last_byte) state_nx = COMPUTE;
            end
            COMPUTE: begin
                bus.mmu_en = 1'b1;
                // a result arriving on the final watchdog cycle still counts
                if (bus.feeder_done)  state_nx = DRAIN;
                else if (timeout_hit) state_nx = IDLE;
            end
            DRAIN: begin
                bus.mmu_en    = 1'b1;
                bus.out_valid = 1'b1;
                if (last_out) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt    <= '0;
            watchdog    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mmu_cycle_q <= '0;
            out_idx_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= accept;
            if (accept) begin
                mem_addr_q  <= byte_cnt;
                mem_wdata_q <= bus.in_data;
                byte_cnt    <= byte_cnt + 3'd1;
            end
            if (state == IDLE && bus.start) begin
                byte_cnt <= '0;
                err_q    <= 1'b0;
            end
            if (state == COMPUTE && !bus.feeder_done && timeout_hit) err_q <= 1'b1;
            watchdog    <= (state == COMPUTE) ? watchdog + WW'(1) : '0;
            // cycle index runs unbroken from COMPUTE entry through the whole drain
            mmu_cycle_q <= (active && active_nx) ? mmu_cycle_q + 3'd1 : 3'd0;
            out_idx_q   <= (state == DRAIN && state_nx == DRAIN) ? out_idx_q + 3'd1 : 3'd0;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mmu_cycle = mmu_cycle_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mmu_sequencer.sv
// tb/tb_mmu_sequencer.sv - directed self-checking bench for mmu_sequencer
module tb_mmu_sequencer;
    localparam int LB = 8;
    localparam int DB = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mmu_sequencer_if bus();

    mmu_sequencer #(.LOAD_BYTES(LB), .DRAIN_BYTES(DB), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // job-level model: mode 0 idle, 1 loading, 2 running (compute then drain)
    int         m_mode   = 0;
    int         m_loaded = 0;
    int         m_t      = 0;
    int         m_ds     = -1;
    bit         m_we     = 0;
    bit         m_err    = 0;
    logic [2:0] m_addr   = '0;
    logic [7:0] m_data   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_loaded = 0; m_t = 0; m_ds = -1;
            m_we = 0; m_err = 0; m_addr = '0; m_data = '0;
        end else begin
            m_we = 0;
            case (m_mode)
                0: if (bus.start) begin m_mode = 1; m_loaded = 0; m_err = 0; end
                1: if (bus.in_valid) begin
                    m_we = 1;
                    m_addr = m_loaded[2:0];
                    m_data = bus.in_data;
                    m_loaded++;
                    if (m_loaded == LB) begin m_mode = 2; m_t = 0; m_ds = -1; end
                end
                default: begin
                    if (m_ds < 0) begin
                        if (bus.feeder_done) m_ds = m_t + 1;
                        else if (m_t == TO - 1) begin m_mode = 0; m_err = 1; end
                    end else if (m_t - m_ds == DB - 1) begin
                        m_mode = 0;
                    end
                    m_t++;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = (m_mode == 2) && (m_ds >= 0);
        check("in_ready",  bus.in_ready,  int'(m_mode == 1));
        check("mmu_en",    bus.mmu_en,    int'(m_mode == 2));
        check("out_valid", bus.out_valid, int'(ev));
        check("busy",      bus.busy,      int'(m_mode != 0));
        check("err",       bus.err,       int'(m_err));
        check("mmu_cycle", bus.mmu_cycle, (m_mode == 2) ? (m_t % 8) : 0);
        check("mem_we",    bus.mem_we,    int'(m_we));
        if (m_we) begin
            check("mem_addr",  bus.mem_addr,  int'(m_addr));
            check("mem_wdata", bus.mem_wdata, int'(m_data));
        end
        if (ev) check("out_idx", bus.out_idx, m_t - m_ds);
    end

    logic [10:0] cap[$];
    int          n_ov = 0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) cap.push_back({bus.mem_addr, bus.mem_wdata});
        if (bus.out_valid === 1'b1) n_ov++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic load(input int gap, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'((i + 1) * 17);
            tick();
            bus.in_valid = 1'b0;
            bus.in_data  = 8'h00;
            if (gap != 0) tick();
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  bus.in_ready,  0);
        check({tag, "_mem_we"},    bus.mem_we,    0);
        check({tag, "_mem_addr"},  bus.mem_addr,  0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_mmu_en"},    bus.mmu_en,    0);
        check({tag, "_mmu_cycle"}, bus.mmu_cycle, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_idx"},   bus.out_idx,   0);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_err"},       bus.err,       0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, cap.size(), LB);
        for (int i = 0; i < LB && i < cap.size(); i++) begin
            logic [10:0] e;
            e = cap[i];
            check({tag, "_waddr"}, e[10:8], i);
            check({tag, "_wdata"}, e[7:0], (i + 1) * 17);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.feeder_done = 1'b0;
        #2 check_reset("por");
        tick();
        rst = 1'b0;
        tick();

        // back-to-back load, feeder result at compute cycle 5
        cap.delete();
        start_job();
        load(0, LB);
        check("j1_cycle0", bus.mmu_cycle, 0);
        repeat (5) tick();
        check("j1_cycle5", bus.mmu_cycle, 5);
        bus.feeder_done = 1'b1;
        tick();
        bus.feeder_done = 1'b0;
        n_ov = 0;
        check("j1_drain_valid", bus.out_valid, 1);
        check("j1_drain_cycle", bus.mmu_cycle, 6);
        repeat (DB) tick();
        check("j1_idle_busy", bus.busy, 0);
        check("j1_nvalid", n_ov, 8);
        check_writes("j1");

        // gapped load, extra offered bytes must be refused
        cap.delete();
        start_job();
        load(1, LB);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        repeat (2) tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        check("j2_cycle5", bus.mmu_cycle, 5);
        bus.feeder_done = 1'b1;
        tick();
        bus.feeder_done = 1'b0;
        repeat (DB) tick();
        check("j2_idle_busy", bus.busy, 0);
        check_writes("j2");

        // watchdog expiry
        start_job();
        load(0, LB);
        repeat (TO) tick();
        check("j3_err", bus.err, 1);
        check("j3_mmu_en", bus.mmu_en, 0);
        check("j3_busy", bus.busy, 0);
        bus.feeder_done = 1'b1;
        tick();
        bus.feeder_done = 1'b0;
        check("j3_done_ignored", bus.busy, 0);
        start_job();
        check("j4_err_cleared", bus.err, 0);

        // result on the last watchdog cycle wins
        load(0, LB);
        repeat (TO - 1) tick();
        check("j4_cycle15", bus.mmu_cycle, 7);
        bus.feeder_done = 1'b1;
        tick();
        bus.feeder_done = 1'b0;
        check("j4_err", bus.err, 0);
        check("j4_drain", bus.out_valid, 1);
        repeat (DB) tick();

        // reset mid-load, then a clean reload from address 0
        start_job();
        load(0, 3);
        rst = 1'b1;
        #1 check_reset("rst_load");
        tick();
        rst = 1'b0;
        cap.delete();
        start_job();
        load(0, LB);
        bus.feeder_done = 1'b1;
        tick();
        bus.feeder_done = 1'b0;
        check_writes("j5");

        // reset mid-drain
        repeat (3) tick();
        check("j5_drain_idx", bus.out_idx, 3);
        rst = 1'b1;
        #1 check_reset("rst_drain");
        tick();
        rst = 1'b0;
        tick();

        start_job();
        load(0, LB);
        repeat (2) tick();
        bus.feeder_done = 1'b1;
        tick();
        bus.feeder_done = 1'b0;
        repeat (DB) tick();
        check("j6_idle_busy", bus.busy, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
